// File: rtl/wb_arbiter_pipelined.sv
// wb_arbiter_pipelined
//   Two-master, one-slave round-robin arbiter for the Wishbone B4 pipelined bus.
//   The grant is registered and held for the owner's whole CYC. An outstanding
//   counter throttles the owner at max_outstanding. It also raises a sticky
//   protocol_err on an orphan ack, or when the owner drops CYC with strobes
//   still unacked.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | no owner, slave side quiet, both masters stalled
//   GNT0  | master 0 owns the slave until m0_cyc falls
//   GNT1  | master 1 owns the slave until m1_cyc falls
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   m0_* / m1_*                 master ports (cyc, stb, we, adr, dat_m in;
//                               dat_s, ack, stall out)
//   s_*                         slave port (cyc, stb, we, adr, dat_m out;
//                               dat_s, ack, stall in)
//   gnt                         one-hot current owner (bit0 = m0, bit1 = m1)
//   protocol_err                sticky bus-violation flag
module wb_arbiter_pipelined #(
  parameter int adr_width       = 16,
  parameter int dat_width       = 16,
  parameter int max_outstanding = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [adr_width-1:0] m0_adr,
  input  logic [dat_width-1:0] m0_dat_m,
  output logic [dat_width-1:0] m0_dat_s,
  output logic                 m0_ack,
  output logic                 m0_stall,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [adr_width-1:0] m1_adr,
  input  logic [dat_width-1:0] m1_dat_m,
  output logic [dat_width-1:0] m1_dat_s,
  output logic                 m1_ack,
  output logic                 m1_stall,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [adr_width-1:0] s_adr,
  output logic [dat_width-1:0] s_dat_m,
  input  logic [dat_width-1:0] s_dat_s,
  input  logic                 s_ack,
  input  logic                 s_stall,
  output logic [1:0]           gnt,
  output logic                 protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam int                CNT_W   = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(max_outstanding);

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             last_q;
  logic             err_q;
  logic [CNT_W-1:0] out_q;
  logic [CNT_W-1:0] out_d;

  logic throttle;
  logic accept;
  logic release_own;
  logic err_set;

  assign throttle    = (out_q == CNT_MAX);
  assign accept      = s_stb && !s_stall;
  assign release_own = ((state_q == GNT0) && !m0_cyc) ||
                       ((state_q == GNT1) && !m1_cyc);

  // Orphan ack: nothing outstanding and nothing accepted in the same cycle.
  assign err_set = (s_ack && (out_q == '0) && !accept) ||
                   (release_own && (out_q != '0));

  // Slave mux and return path. Forced quiet during reset so that in-flight
  // acks never reach a master while the arbiter is being cleared.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_m  = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m0_dat_s = '0;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;
    m1_dat_s = '0;
    if (!rst) begin
      case (state_q)
        GNT0: begin
          s_cyc    = m0_cyc;
          s_stb    = m0_stb && !throttle;
          s_we     = m0_we;
          s_adr    = m0_adr;
          s_dat_m  = m0_dat_m;
          m0_ack   = s_ack;
          m0_stall = s_stall || throttle;
          m0_dat_s = s_dat_s;
        end
        GNT1: begin
          s_cyc    = m1_cyc;
          s_stb    = m1_stb && !throttle;
          s_we     = m1_we;
          s_adr    = m1_adr;
          s_dat_m  = m1_dat_m;
          m1_ack   = s_ack;
          m1_stall = s_stall || throttle;
          m1_dat_s = s_dat_s;
        end
        default: ;
      endcase
    end
  end

  // Counter is zeroed whenever there is no owner or the owner is releasing,
  // so a new grant always starts from a clean count.
  always_comb begin
    out_d = out_q;
    if ((state_q == IDLE) || release_own) begin
      out_d = '0;
    end else if (accept && !s_ack) begin
      if (out_q != '1) out_d = out_q + CNT_W'(1);
    end else if (!accept && s_ack) begin
      if (out_q != '0) out_d = out_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      if (err_set) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // Tie goes to the master that did not own the bus last.
          if (m0_cyc && (!m1_cyc || last_q)) begin
            state_q <= GNT0;
            gnt_q   <= 2'b01;
          end else if (m1_cyc) begin
            state_q <= GNT1;
            gnt_q   <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_cyc) begin
            last_q <= 1'b0;
            if (m1_cyc) begin
              state_q <= GNT1;
              gnt_q   <= 2'b10;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            last_q <= 1'b1;
            if (m0_cyc) begin
              state_q <= GNT0;
              gnt_q   <= 2'b01;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 2'b00;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_wb_arbiter_pipelined.sv
// tb_wb_arbiter_pipelined
//   Directed bench for wb_arbiter_pipelined: two scripted pipelined masters and
//   a fixed-latency slave with a small memory. Every expected value is a
//   hand-derived constant or comes from the bench's own bookkeeping.
module tb_wb_arbiter_pipelined;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_stall;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_m, m0_dat_s;
  logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_stall;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_m, m1_dat_s;
  logic          s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_m, s_dat_s;
  logic [1:0]    gnt;
  logic          protocol_err;

  wb_arbiter_pipelined #(.adr_width(AW), .dat_width(DW), .max_outstanding(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_m(m0_dat_m), .m0_dat_s(m0_dat_s), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_m(m1_dat_m), .m1_dat_s(m1_dat_s), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_m(s_dat_m),
    .s_dat_s(s_dat_s), .s_ack(s_ack), .s_stall(s_stall),
    .gnt(gnt), .protocol_err(protocol_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // master scripts
  bit          go[2];
  bit          hold[2];
  int          mn[2], iss[2], ackd[2];
  logic        mt_we[2][16];
  logic [15:0] mt_adr[2][16];
  logic [15:0] mt_dat[2][16];
  logic [15:0] rd[2][16];

  // slave model
  logic [15:0] mem[256];
  int          lat;
  bit          sch_ack[1024];
  logic [15:0] sch_dat[1024];
  bit          inj_ack;
  int          cyc_n;
  int          tb_out, tb_out_max;
  logic [1:0]  gnt_log[1024];

  // statistics
  int st_thr, st_sstb0, st_m0_unstall, st_m1_leak, st_dat_leak;

  task automatic clear_stats();
    st_thr = 0; st_sstb0 = 0; st_m0_unstall = 0; st_m1_leak = 0; st_dat_leak = 0;
    tb_out_max = 0;
  endtask

  task automatic load(input int m, input int n, input logic we,
                      input logic [15:0] adr0, input logic [15:0] dat0);
    for (int i = 0; i < n; i++) begin
      mt_we[m][i]  = we;
      mt_adr[m][i] = adr0 + 16'(i);
      mt_dat[m][i] = dat0 + 16'(i);
    end
    mn[m] = n; iss[m] = 0; ackd[m] = 0; hold[m] = 1'b0; go[m] = 1'b1;
  endtask

  function automatic bit busy();
    bit b = 1'b0;
    for (int m = 0; m < 2; m++)
      if (go[m] && (ackd[m] < mn[m] || hold[m])) b = 1'b1;
    return b;
  endfunction

  task automatic drive_masters();
    logic c[2];
    logic s[2];
    int   k[2];
    for (int m = 0; m < 2; m++) begin
      c[m] = go[m] && (ackd[m] < mn[m] || hold[m]);
      s[m] = c[m] && (iss[m] < mn[m]);
      k[m] = (iss[m] < mn[m]) ? iss[m] : 0;
    end
    m0_cyc = c[0]; m0_stb = s[0]; m0_we = mt_we[0][k[0]];
    m0_adr = mt_adr[0][k[0]]; m0_dat_m = mt_dat[0][k[0]];
    m1_cyc = c[1]; m1_stb = s[1]; m1_we = mt_we[1][k[1]];
    m1_adr = mt_adr[1][k[1]]; m1_dat_m = mt_dat[1][k[1]];
  endtask

  task automatic step_to_neg();
    logic       stb_v[2], stall_v[2], ack_v[2];
    logic [15:0] dat_v[2];
    drive_masters();
    s_stall = 1'b0;
    s_ack   = sch_ack[cyc_n] || inj_ack;
    s_dat_s = sch_ack[cyc_n] ? sch_dat[cyc_n] : 16'hBEEF;
    @(negedge clk);
    gnt_log[cyc_n] = gnt;
    if (s_stb && !s_stall) begin
      if (s_we) begin
        mem[s_adr[7:0]]      = s_dat_m;
        sch_dat[cyc_n + lat] = 16'hDEAD;
      end else begin
        sch_dat[cyc_n + lat] = mem[s_adr[7:0]];
      end
      sch_ack[cyc_n + lat] = 1'b1;
      tb_out++;
    end
    if (sch_ack[cyc_n] && !rst) tb_out--;
    if (tb_out > tb_out_max) tb_out_max = tb_out;
    stb_v[0] = m0_stb; stall_v[0] = m0_stall; ack_v[0] = m0_ack; dat_v[0] = m0_dat_s;
    stb_v[1] = m1_stb; stall_v[1] = m1_stall; ack_v[1] = m1_ack; dat_v[1] = m1_dat_s;
    for (int m = 0; m < 2; m++) begin
      if (stb_v[m] && !stall_v[m]) iss[m]++;
      if (ack_v[m]) begin
        if (ackd[m] < 16) rd[m][ackd[m]] = dat_v[m];
        ackd[m]++;
      end
    end
    if (m1_cyc && gnt != 2'b10 && (m1_ack || !m1_stall)) st_m1_leak++;
    if (gnt != 2'b10 && m1_dat_s != 16'h0) st_dat_leak++;
    if (gnt == 2'b10 && m1_stb && m1_stall) st_thr++;
    if (gnt == 2'b10 && m1_stb && !s_stb) st_sstb0++;
    if (!m0_stall) st_m0_unstall++;
  endtask

  task automatic step_to_pos();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic tick();
    step_to_neg();
    step_to_pos();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run(input string tag, input int budget);
    int i = 0;
    while (busy() && i < budget) begin
      tick();
      i++;
    end
    chk({tag, "_done"}, 32'(busy()), 0);
    go[0] = 1'b0;
    go[1] = 1'b0;
  endtask

  task automatic clear_sched();
    for (int i = cyc_n; i < cyc_n + 24; i++) sch_ack[i] = 1'b0;
    tb_out = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go[0] = 1'b0; go[1] = 1'b0; hold[0] = 1'b0; hold[1] = 1'b0;
    inj_ack = 1'b0;
    clear_sched();
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    int b;
    int good;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    for (int i = 0; i < 1024; i++) begin
      sch_ack[i] = 1'b0;
      sch_dat[i] = 16'h0;
      gnt_log[i] = 2'b00;
    end
    for (int m = 0; m < 2; m++) begin
      go[m] = 1'b0; hold[m] = 1'b0; mn[m] = 0; iss[m] = 0; ackd[m] = 0;
      for (int i = 0; i < 16; i++) begin
        mt_we[m][i] = 1'b0; mt_adr[m][i] = 16'h0; mt_dat[m][i] = 16'h0; rd[m][i] = 16'h0;
      end
    end
    lat = 1; inj_ack = 1'b0; cyc_n = 0; tb_out = 0;
    clear_stats();

    // reset state
    rst = 1'b1;
    step_to_neg();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_s_dat_m", s_dat_m, 0);
    chk("rst_m0_stall", m0_stall, 1);
    chk("rst_m1_stall", m1_stall, 1);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_err", protocol_err, 0);
    step_to_pos();
    tick();
    rst = 1'b0;

    // single m0 write, zero wait states
    lat = 1;
    load(0, 1, 1'b1, 16'd1, 16'd101);
    step_to_neg();
    chk("t1_cyc_lag", s_cyc, 0);
    chk("t1_stall_idle", m0_stall, 1);
    step_to_pos();
    step_to_neg();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_s_cyc", s_cyc, 1);
    chk("t1_s_stb", s_stb, 1);
    chk("t1_s_adr", s_adr, 16'd1);
    chk("t1_s_dat_m", s_dat_m, 16'd101);
    step_to_pos();
    step_to_neg();
    chk("t1_ack", m0_ack, 1);
    step_to_pos();
    step_to_neg();
    chk("t1_gnt_hold", gnt, 2'b01);
    chk("t1_ack_off", m0_ack, 0);
    step_to_pos();
    step_to_neg();
    chk("t1_gnt_rel", gnt, 2'b00);
    chk("t1_err", protocol_err, 0);
    chk("t1_mem", mem[1], 16'd101);
    step_to_pos();
    go[0] = 1'b0;

    // tie right after m0 owned the bus: m1 goes first
    b = cyc_n;
    load(0, 1, 1'b0, 16'd5, 16'd0);
    load(1, 1, 1'b0, 16'd6, 16'd0);
    run("t2a", 30);
    ticks(2);
    chk("t2a_first", gnt_log[b+1], 2'b10);
    chk("t2a_second", gnt_log[b+4], 2'b01);
    chk("t2a_rd0", rd[0][0], 16'hA005);
    chk("t2a_rd1", rd[1][0], 16'hA006);

    // tie right after reset: m0 first, then m1 back-to-back
    do_reset();
    b = cyc_n;
    load(0, 1, 1'b0, 16'd5, 16'd0);
    load(1, 1, 1'b0, 16'd6, 16'd0);
    run("t2b", 30);
    ticks(3);
    chk("t2b_first", gnt_log[b+1], 2'b01);
    chk("t2b_first_end", gnt_log[b+3], 2'b01);
    chk("t2b_b2b", gnt_log[b+4], 2'b10);
    chk("t2b_idle", gnt_log[b+7], 2'b00);
    chk("t2b_rd1", rd[1][0], 16'hA006);

    // m1 streams 10 writes, three wait states, throttled at 4
    lat = 4;
    clear_stats();
    load(1, 10, 1'b1, 16'd11, 16'd211);
    run("t3", 80);
    ticks(2);
    good = 0;
    for (int i = 0; i < 10; i++) if (mem[11+i] == 16'(211 + i)) good++;
    chk("t3_acks", ackd[1], 10);
    chk("t3_mem", good, 10);
    chk("t3_throttle_stall", st_thr, 2);
    chk("t3_throttle_stb", st_sstb0, 2);
    chk("t3_max_out", tb_out_max, 4);
    chk("t3_m0_stall", st_m0_unstall, 0);
    chk("t3_err", protocol_err, 0);

    // m0 holds cyc while m1 waits
    lat = 1;
    clear_stats();
    load(0, 1, 1'b1, 16'd30, 16'd330);
    hold[0] = 1'b1;
    load(1, 1, 1'b0, 16'd7, 16'd0);
    ticks(10);
    chk("t4_gnt_held", gnt, 2'b01);
    chk("t4_m0_acked", ackd[0], 1);
    chk("t4_m1_waiting", ackd[1], 0);
    hold[0] = 1'b0;
    run("t4", 30);
    ticks(2);
    chk("t4_m1_acked", ackd[1], 1);
    chk("t4_m1_rd", rd[1][0], 16'hA007);
    chk("t4_m1_leak", st_m1_leak, 0);
    chk("t4_dat_leak", st_dat_leak, 0);
    chk("t4_err", protocol_err, 0);

    // orphan ack
    do_reset();
    inj_ack = 1'b1;
    step_to_neg();
    chk("t5_err_same", protocol_err, 0);
    step_to_pos();
    inj_ack = 1'b0;
    step_to_neg();
    chk("t5_err_set", protocol_err, 1);
    step_to_pos();
    ticks(3);
    chk("t5_err_sticky", protocol_err, 1);
    do_reset();
    chk("t5_err_clr", protocol_err, 0);

    // reset in the middle of an m0 burst with 2 outstanding
    lat = 6;
    load(0, 4, 1'b1, 16'd40, 16'd440);
    b = 0;
    while (tb_out != 2 && b < 20) begin
      tick();
      b++;
    end
    chk("t6_two_out", tb_out, 2);
    rst = 1'b1;
    go[0] = 1'b0;
    clear_sched();
    step_to_neg();
    chk("t6_in_rst_cyc", s_cyc, 0);
    chk("t6_in_rst_ack", m0_ack, 0);
    step_to_pos();
    rst = 1'b0;
    step_to_neg();
    chk("t6_gnt", gnt, 2'b00);
    chk("t6_s_cyc", s_cyc, 0);
    chk("t6_err", protocol_err, 0);
    chk("t6_stall", m0_stall, 1);
    step_to_pos();
    lat = 1;
    load(0, 1, 1'b1, 16'd50, 16'd550);
    run("t6", 30);
    ticks(2);
    chk("t6_after_ack", ackd[0], 1);
    chk("t6_after_err", protocol_err, 0);
    chk("t6_after_mem", mem[50], 16'd550);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_pipelined.md
Name: wb_arbiter_pipelined

Overview:
Two-master, one-slave arbiter for the Wishbone B4 pipelined bus. It shares a single pipelined slave (e.g. wb_slave_pipelined) between master port 0 and master port 1 using round-robin fairness. The grant is held for the entire CYC of the owning master. An outstanding-transfer counter throttles the owner and flags protocol violations.

Parameters:
adr_width, 16, address width of all ports
dat_width, 16, data width of all ports
max_outstanding, 4, max accepted-but-unacked strobes; range 1..15

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
m0_cyc, m0_stb, m0_we  input  1 each  master 0 cycle, strobe, write enable
m0_adr  input  adr_width  master 0 address
m0_dat_m  input  dat_width  master 0 write data
m0_dat_s  output  dat_width  read data to master 0
m0_ack, m0_stall  output  1 each  master 0 acknowledge, stall
m1_*  (same set as m0_*)  master 1 port
s_cyc, s_stb, s_we  output  1 each  slave cycle, strobe, write enable
s_adr  output  adr_width  slave address
s_dat_m  output  dat_width  slave write data
s_dat_s  input  dat_width  slave read data
s_ack, s_stall  input  1 each  slave acknowledge, stall
gnt  output  2  one-hot current grant (bit0 = m0, bit1 = m1)
protocol_err  output  1  sticky violation flag

Behaviour:
- Reset: clk and rst as named; reset is synchronous and active-high. On rst: state=IDLE, gnt=00, last=1 (so m0 wins the first tie), outstanding=0, protocol_err=0.
- Outputs while in reset or IDLE: s_cyc=0, s_stb=0, s_we=0, s_adr=0, s_dat_m=0, m*_ack=0, m*_stall=1.
- FSM states: IDLE, GNT0, GNT1. The grant is registered, so a granted master's CYC reaches the slave 1 cycle after it is sampled.
- IDLE transitions:
  - only m0_cyc -> GNT0; only m1_cyc -> GNT1.
  - both -> the master with index != last.
- GNTx holding: stay while mx_cyc=1.
- GNTx release: on mx_cyc=0, set last=x, then:
  - if the other master's cyc=1 -> go directly to the other GNT (back-to-back, no IDLE cycle);
  - else -> IDLE.
- Slave-side mux, combinational from the registered state:
  - s_cyc=mx_cyc, s_we=mx_we, s_adr=mx_adr, s_dat_m=mx_dat_m.
  - s_stb = mx_stb && !throttle.
- Owner return path: mx_ack=s_ack, mx_dat_s=s_dat_s, mx_stall = s_stall || throttle.
- Non-owner: ack=0, stall=1, dat_s=0.
- throttle = (outstanding == max_outstanding).
- Outstanding counter:
  - +1 on s_stb && !s_stall; -1 on s_ack; both in the same cycle -> unchanged.
  - Never wraps; saturating hold at the bounds.
  - Cleared on grant change.
- protocol_err is set and held until rst on either event:
  - s_ack while outstanding==0 and no acceptance in the same cycle;
  - owner drops cyc while outstanding>0.
- Reset asserted mid-transfer: immediate return to IDLE on the next edge; in-flight acks are dropped and no error is raised.

Test Plan:
- Single m0 write, adr=1 dat=101, slave waitcycles=0 -> s_cyc rises 1 cycle after m0_cyc; m0_ack 1 cycle after acceptance; gnt=01; protocol_err=0.
- m0 and m1 assert cyc on the same edge after reset, each doing a single read -> m0 served first (gnt=01), then gnt=10 directly with no IDLE cycle; next tie goes to m1 if m0 won last.
- m1 streams 10 pipelined writes (adr 11..20, dat 211..220) with max_outstanding=4 and slave waitcycles=3 -> s_stb deasserts and m1_stall=1 whenever 4 are unacked; all 10 acks reach m1; m0_stall=1 throughout.
- m0 holds cyc while m1 requests -> gnt stays 01 until m0_cyc falls; m1 sees stall=1, ack=0 the entire time.
- Inject s_ack with no outstanding strobe -> protocol_err=1 next cycle, held until rst.
- Assert rst during m0 burst with 2 outstanding -> next edge: gnt=00, s_cyc=0, outstanding=0, protocol_err=0.
